// File: rtl/ahb_slave_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_slave_arbiter_pkg                                            |
// | AHB transfer/burst encodings and arbiter state type.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_SINGLE    = 2'd1,
        ARB_BURST_FIX = 2'd2,
        ARB_BURST_INC = 2'd3
    } arb_state_type;

    localparam int BEAT_CNT_W = 4;

    // Beats remaining after the NONSEQ of a fixed burst; zero for SINGLE/INCR.
    function automatic logic [BEAT_CNT_W-1:0] burst_last_beat(input hburst_type b);
        logic [BEAT_CNT_W-1:0] v;
        case (b)
            BURST_WRAP4,  BURST_INCR4:  v = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  v = 4'd7;
            BURST_WRAP16, BURST_INCR16: v = 4'd15;
            default:                    v = 4'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_arbiter_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_rr_picker                                                    |
// | Combinational round-robin winner search starting at i_rr_ptr.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ahb_rr_picker #(
    parameter int MASTER_NUM   = 2,
    parameter int MASTER_IDX_W = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0]   i_hreq,
    input  logic [MASTER_IDX_W-1:0] i_rr_ptr,
    output logic [MASTER_IDX_W-1:0] o_idx,
    output logic                    o_valid
);

    logic [2*MASTER_NUM-1:0] w_req2;
    logic [2*MASTER_NUM-1:0] w_rot;
    logic [MASTER_IDX_W:0]   w_sum;

    assign w_req2 = {i_hreq, i_hreq};
    assign w_rot  = w_req2 >> i_rr_ptr;

    // Descending scan so the smallest distance from the pointer wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int k = MASTER_NUM - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_rr_ptr} + (MASTER_IDX_W + 1)'(k);
                if (w_sum >= (MASTER_IDX_W + 1)'(MASTER_NUM)) begin
                    w_sum = w_sum - (MASTER_IDX_W + 1)'(MASTER_NUM);
                end
                o_idx   = w_sum[MASTER_IDX_W-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_slave_arbiter                                                |
// | Per-slave round-robin arbiter holding grant across AHB bursts.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ahb_slave_arbiter #(
    parameter int MASTER_NUM   = 2,
    parameter int MASTER_IDX_W = $clog2(MASTER_NUM)
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [MASTER_NUM-1:0]     hreq,
    input  logic [2*MASTER_NUM-1:0]   htrans,
    input  logic [3*MASTER_NUM-1:0]   hburst,
    input  logic                      hready,
    output logic [MASTER_NUM-1:0]     hgrant,
    output logic                      hsel_slv,
    output logic [MASTER_IDX_W-1:0]   hmaster_addr,
    output logic [MASTER_IDX_W-1:0]   hmaster_data,
    output logic [MASTER_NUM-1:0]     hwait
);
    import ahb_slave_arbiter_pkg::*;

    arb_state_type             r_state;
    logic [MASTER_NUM-1:0]     r_hgrant;
    logic [MASTER_IDX_W-1:0]   r_hmaster_addr;
    logic [MASTER_IDX_W-1:0]   r_hmaster_data;
    logic [MASTER_IDX_W-1:0]   r_rr_ptr;
    logic [BEAT_CNT_W-1:0]     r_beat_cnt;

    htrans_type                w_trans [MASTER_NUM];
    hburst_type                w_burst [MASTER_NUM];
    logic [MASTER_NUM-1:0]     w_win_onehot;
    logic [MASTER_IDX_W-1:0]   w_win_idx;
    logic [MASTER_IDX_W-1:0]   w_next_ptr;
    logic                      w_win_vld;
    htrans_type                w_own_trans;
    hburst_type                w_own_burst;
    logic                      w_own_req;
    logic                      w_hsel;
    logic                      w_release;
    logic                      w_start_fix;
    logic                      w_start_inc;
    logic                      w_dec;

    for (genvar g = 0; g < MASTER_NUM; g++) begin : g_unpack
        assign w_trans[g]      = htrans_type'(htrans[2*g +: 2]);
        assign w_burst[g]      = hburst_type'(hburst[3*g +: 3]);
        assign w_win_onehot[g] = (w_win_idx == MASTER_IDX_W'(g));
    end

    ahb_rr_picker #(
        .MASTER_NUM   (MASTER_NUM),
        .MASTER_IDX_W (MASTER_IDX_W)
    ) u_rr_picker (
        .i_hreq   (hreq),
        .i_rr_ptr (r_rr_ptr),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_vld)
    );

    assign w_next_ptr  = (int'(w_win_idx) == MASTER_NUM - 1) ? '0
                                                             : w_win_idx + MASTER_IDX_W'(1);
    assign w_own_trans = w_trans[r_hmaster_addr];
    assign w_own_burst = w_burst[r_hmaster_addr];
    assign w_own_req   = hreq[r_hmaster_addr];
    assign w_hsel      = |(r_hgrant & hreq);

    // Owner-side decode: what the current address phase does to the grant.
    always_comb begin
        w_release   = 1'b0;
        w_start_fix = 1'b0;
        w_start_inc = 1'b0;
        w_dec       = 1'b0;
        if (r_state != ARB_IDLE) begin
            if (!w_own_req) begin
                w_release = 1'b1;
            end else if (w_own_trans == TRANS_IDLE) begin
                w_release = 1'b1;
            end else if (w_own_trans == TRANS_NONSEQ) begin
                if (r_state == ARB_BURST_INC) begin
                    w_release = 1'b1;
                end else if (burst_last_beat(w_own_burst) != '0) begin
                    w_start_fix = 1'b1;
                end else if (w_own_burst == BURST_INCR) begin
                    w_start_inc = 1'b1;
                end else begin
                    w_release = 1'b1;
                end
            end else if (w_own_trans == TRANS_SEQ && r_state == ARB_BURST_FIX) begin
                // The SEQ seen with one beat left is the final address phase.
                if (r_beat_cnt <= BEAT_CNT_W'(1)) begin
                    w_release = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            r_state        <= ARB_IDLE;
            r_hgrant       <= '0;
            r_hmaster_addr <= '0;
            r_hmaster_data <= '0;
            r_rr_ptr       <= '0;
            r_beat_cnt     <= '0;
        end else if (hready) begin
            if (w_hsel && (w_own_trans == TRANS_NONSEQ || w_own_trans == TRANS_SEQ)) begin
                r_hmaster_data <= r_hmaster_addr;
            end
            if (r_state == ARB_IDLE || w_release) begin
                r_beat_cnt <= '0;
                if (w_win_vld) begin
                    r_state        <= ARB_SINGLE;
                    r_hgrant       <= w_win_onehot;
                    r_hmaster_addr <= w_win_idx;
                    r_rr_ptr       <= w_next_ptr;
                end else begin
                    r_state  <= ARB_IDLE;
                    r_hgrant <= '0;
                end
            end else if (w_start_fix) begin
                r_state    <= ARB_BURST_FIX;
                r_beat_cnt <= burst_last_beat(w_own_burst);
            end else if (w_start_inc) begin
                r_state    <= ARB_BURST_INC;
                r_beat_cnt <= '0;
            end else if (w_dec) begin
                r_beat_cnt <= r_beat_cnt - BEAT_CNT_W'(1);
            end
        end
    end

    assign hgrant       = r_hgrant;
    assign hsel_slv     = w_hsel;
    assign hmaster_addr = r_hmaster_addr;
    assign hmaster_data = r_hmaster_data;
    assign hwait        = hreq & ~r_hgrant;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ahb_slave_arbiter                                             |
// | Directed self-checking bench for the two-master slave arbiter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ahb_slave_arbiter;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_WRAP4  = 3'd2;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic [1:0] hreq;
    logic [3:0] htrans;
    logic [5:0] hburst;
    logic       hready;
    logic [1:0] hgrant;
    logic       hsel_slv;
    logic [0:0] hmaster_addr;
    logic [0:0] hmaster_data;
    logic [1:0] hwait;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_slave_arbiter #(
        .MASTER_NUM   (2),
        .MASTER_IDX_W (1)
    ) dut (
        .hclk         (hclk),
        .hreset_n     (hreset_n),
        .hreq         (hreq),
        .htrans       (htrans),
        .hburst       (hburst),
        .hready       (hready),
        .hgrant       (hgrant),
        .hsel_slv     (hsel_slv),
        .hmaster_addr (hmaster_addr),
        .hmaster_data (hmaster_data),
        .hwait        (hwait)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input bit m, input logic req, input logic [1:0] tr, input logic [2:0] bu);
        if (m) begin
            hreq[1] = req; htrans[3:2] = tr; hburst[5:3] = bu;
        end else begin
            hreq[0] = req; htrans[1:0] = tr; hburst[2:0] = bu;
        end
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        hready   = 1'b1;
        drive(0, 1'b0, T_IDLE, B_SINGLE);
        drive(1, 1'b0, T_IDLE, B_SINGLE);
        tick();
        tick();
        hreset_n = 1'b1;
    endtask

    task automatic go_idle();
        hready = 1'b1;
        drive(0, 1'b0, T_IDLE, B_SINGLE);
        drive(1, 1'b0, T_IDLE, B_SINGLE);
        tick();
        tick();
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        hready   = 1'b1;
        drive(0, 1'b1, T_NSEQ, B_SINGLE);
        drive(1, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        tick();
        n_tests++; if (hgrant !== 2'b00) begin n_fail++; $display("FAIL reset_hgrant: got %b expected %b", hgrant, 2'b00); end
        n_tests++; if (hsel_slv !== 1'b0) begin n_fail++; $display("FAIL reset_hsel: got %b expected %b", hsel_slv, 1'b0); end
        n_tests++; if (hmaster_addr !== 1'b0) begin n_fail++; $display("FAIL reset_maddr: got %b expected %b", hmaster_addr, 1'b0); end
        n_tests++; if (hmaster_data !== 1'b0) begin n_fail++; $display("FAIL reset_mdata: got %b expected %b", hmaster_data, 1'b0); end
        n_tests++; if (hwait !== 2'b11) begin n_fail++; $display("FAIL reset_hwait: got %b expected %b", hwait, 2'b11); end
        hreset_n = 1'b1;
        go_idle();
    endtask

    task automatic test_single_m1();
        do_reset();
        drive(1, 1'b1, T_NSEQ, B_SINGLE);
        #1;
        n_tests++; if (hwait !== 2'b10) begin n_fail++; $display("FAIL single_wait_req: got %b expected %b", hwait, 2'b10); end
        n_tests++; if (hgrant !== 2'b00) begin n_fail++; $display("FAIL single_nogrant: got %b expected %b", hgrant, 2'b00); end
        tick();
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b expected %b", hgrant, 2'b10); end
        n_tests++; if (hmaster_addr !== 1'b1) begin n_fail++; $display("FAIL single_maddr: got %b expected %b", hmaster_addr, 1'b1); end
        n_tests++; if (hwait !== 2'b00) begin n_fail++; $display("FAIL single_wait_gnt: got %b expected %b", hwait, 2'b00); end
        n_tests++; if (hsel_slv !== 1'b1) begin n_fail++; $display("FAIL single_hsel: got %b expected %b", hsel_slv, 1'b1); end
        tick();
        drive(1, 1'b0, T_IDLE, B_SINGLE);
        #1;
        n_tests++; if (hsel_slv !== 1'b0) begin n_fail++; $display("FAIL single_hsel_drop: got %b expected %b", hsel_slv, 1'b0); end
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL single_mdata: got %b expected %b", hmaster_data, 1'b1); end
        tick();
        n_tests++; if (hgrant !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b expected %b", hgrant, 2'b00); end
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL single_mdata_hold: got %b expected %b", hmaster_data, 1'b1); end
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(0, 1'b1, T_NSEQ, B_SINGLE);
        drive(1, 1'b1, T_NSEQ, B_SINGLE);
        #1;
        n_tests++; if (hwait !== 2'b11) begin n_fail++; $display("FAIL rr_wait_both: got %b expected %b", hwait, 2'b11); end
        tick();
        n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL rr_first_m0: got %b expected %b", hgrant, 2'b01); end
        n_tests++; if (hwait !== 2'b10) begin n_fail++; $display("FAIL rr_wait_m1: got %b expected %b", hwait, 2'b10); end
        tick();
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL rr_then_m1: got %b expected %b", hgrant, 2'b10); end
        n_tests++; if (hmaster_addr !== 1'b1) begin n_fail++; $display("FAIL rr_maddr_m1: got %b expected %b", hmaster_addr, 1'b1); end
        n_tests++; if (hmaster_data !== 1'b0) begin n_fail++; $display("FAIL rr_mdata_m0: got %b expected %b", hmaster_data, 1'b0); end
        n_tests++; if (hwait !== 2'b01) begin n_fail++; $display("FAIL rr_wait_m0: got %b expected %b", hwait, 2'b01); end
        tick();
        n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL rr_wrap_m0: got %b expected %b", hgrant, 2'b01); end
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL rr_mdata_m1: got %b expected %b", hmaster_data, 1'b1); end
        go_idle();
    endtask

    task automatic test_incr4();
        do_reset();
        drive(0, 1'b1, T_NSEQ, B_INCR4);
        drive(1, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b == 1) drive(0, 1'b1, T_SEQ, B_INCR4);
            #1;
            n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL incr4_hold_beat%0d: got %b expected %b", b + 1, hgrant, 2'b01); end
            n_tests++; if (hwait !== 2'b10) begin n_fail++; $display("FAIL incr4_wait_beat%0d: got %b expected %b", b + 1, hwait, 2'b10); end
            tick();
        end
        drive(0, 1'b0, T_IDLE, B_SINGLE);
        #1;
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL incr4_handover: got %b expected %b", hgrant, 2'b10); end
        n_tests++; if (hmaster_addr !== 1'b1) begin n_fail++; $display("FAIL incr4_maddr: got %b expected %b", hmaster_addr, 1'b1); end
        n_tests++; if (hwait !== 2'b00) begin n_fail++; $display("FAIL incr4_wait_after: got %b expected %b", hwait, 2'b00); end
        go_idle();
    endtask

    task automatic test_stall_incr8();
        do_reset();
        drive(1, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        drive(0, 1'b1, T_NSEQ, B_INCR8);
        #1;
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL stall_pre_grant: got %b expected %b", hgrant, 2'b10); end
        tick();
        hready = 1'b0;
        #1;
        n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL stall_m0_grant: got %b expected %b", hgrant, 2'b01); end
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL stall_mdata_pre: got %b expected %b", hmaster_data, 1'b1); end
        for (int s = 0; s < 3; s++) begin
            tick();
            n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL stall_grant_c%0d: got %b expected %b", s, hgrant, 2'b01); end
            n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL stall_mdata_c%0d: got %b expected %b", s, hmaster_data, 1'b1); end
        end
        hready = 1'b1;
        tick();
        n_tests++; if (hmaster_data !== 1'b0) begin n_fail++; $display("FAIL stall_mdata_beat1: got %b expected %b", hmaster_data, 1'b0); end
        drive(0, 1'b1, T_SEQ, B_INCR8);
        tick();
        drive(0, 1'b1, T_BUSY, B_INCR8);
        tick();
        drive(0, 1'b1, T_SEQ, B_INCR8);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL incr8_hold_beat%0d: got %b expected %b", i + 3, hgrant, 2'b01); end
            tick();
        end
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL incr8_release: got %b expected %b", hgrant, 2'b10); end
        n_tests++; if (hmaster_addr !== 1'b1) begin n_fail++; $display("FAIL incr8_maddr: got %b expected %b", hmaster_addr, 1'b1); end
        go_idle();
    endtask

    task automatic test_incr_undef();
        do_reset();
        drive(1, 1'b1, T_NSEQ, B_INCR);
        tick();
        n_tests++; if (hmaster_addr !== 1'b1) begin n_fail++; $display("FAIL undef_maddr: got %b expected %b", hmaster_addr, 1'b1); end
        n_tests++; if (hmaster_data !== 1'b0) begin n_fail++; $display("FAIL undef_mdata_trail: got %b expected %b", hmaster_data, 1'b0); end
        drive(0, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        drive(1, 1'b1, T_SEQ, B_INCR);
        #1;
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL undef_mdata_beat1: got %b expected %b", hmaster_data, 1'b1); end
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL undef_hold_beat%0d: got %b expected %b", i + 2, hgrant, 2'b10); end
            tick();
        end
        drive(1, 1'b1, T_IDLE, B_INCR);
        #1;
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL undef_hold_idle: got %b expected %b", hgrant, 2'b10); end
        tick();
        n_tests++; if (hgrant !== 2'b01) begin n_fail++; $display("FAIL undef_release: got %b expected %b", hgrant, 2'b01); end
        n_tests++; if (hmaster_addr !== 1'b0) begin n_fail++; $display("FAIL undef_maddr_m0: got %b expected %b", hmaster_addr, 1'b0); end
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL undef_mdata_hold: got %b expected %b", hmaster_data, 1'b1); end
        go_idle();
    endtask

    task automatic test_reset_mid_wrap4();
        do_reset();
        drive(1, 1'b1, T_NSEQ, B_WRAP4);
        tick();
        tick();
        drive(1, 1'b1, T_SEQ, B_WRAP4);
        #1;
        n_tests++; if (hmaster_data !== 1'b1) begin n_fail++; $display("FAIL wrap4_mdata: got %b expected %b", hmaster_data, 1'b1); end
        hreset_n = 1'b0;
        tick();
        n_tests++; if (hgrant !== 2'b00) begin n_fail++; $display("FAIL wrap4_rst_grant: got %b expected %b", hgrant, 2'b00); end
        n_tests++; if (hsel_slv !== 1'b0) begin n_fail++; $display("FAIL wrap4_rst_hsel: got %b expected %b", hsel_slv, 1'b0); end
        n_tests++; if (hmaster_data !== 1'b0) begin n_fail++; $display("FAIL wrap4_rst_mdata: got %b expected %b", hmaster_data, 1'b0); end
        n_tests++; if (hmaster_addr !== 1'b0) begin n_fail++; $display("FAIL wrap4_rst_maddr: got %b expected %b", hmaster_addr, 1'b0); end
        n_tests++; if (hwait !== 2'b10) begin n_fail++; $display("FAIL wrap4_rst_wait: got %b expected %b", hwait, 2'b10); end
        hreset_n = 1'b1;
        drive(1, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        n_tests++; if (hgrant !== 2'b10) begin n_fail++; $display("FAIL wrap4_regrant: got %b expected %b", hgrant, 2'b10); end
        go_idle();
    endtask

    initial begin
        hreset_n = 1'b0;
        hready   = 1'b1;
        hreq     = '0;
        htrans   = '0;
        hburst   = '0;
        test_reset();
        test_single_m1();
        test_round_robin();
        test_incr4();
        test_stall_incr8();
        test_incr_undef();
        test_reset_mid_wrap4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
